// File: rtl/hififo_ctrl_regs_if.sv
// PIO bus between the host-side request logic and the control register block.
// master: drives writes, read requests and completion ready.
// slave:  the register block, returns completions and the read-release pulse.
interface hififo_ctrl_regs_if;
  logic        wr_valid;
  logic [5:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rr_valid;
  logic [5:0]  rr_addr;
  logic        rr_ready;
  logic        rc_valid;
  logic        rc_ready;
  logic [31:0] rc_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rr_valid, rr_addr, rc_ready,
    input  rr_ready, rc_valid, rc_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rr_valid, rr_addr, rc_ready,
    output rr_ready, rc_valid, rc_data
  );
endinterface

// File: rtl/hififo_ctrl_regs.sv
// Control/status register block for a multi-channel host FIFO.
// Word map: 0 irq status (clear on read), 1 channel-present mask, 2 build stamp,
// 3/4 FIFO reset register (write 3 sets bits, write 4 clears), 5 irq mask,
// 32+i channel i status word. Reads run through a small IDLE/LOOKUP/RESP/DONE FSM.
// Optional feature: define HIFIFO_IRQ_MASK_EN to build the irq mask register;
// without it the mask reads as 0 and writes to word 5 are dropped.
module hififo_ctrl_regs #(
  parameter int unsigned NCH       = 8,
  parameter logic [15:0] ENABLE    = 16'h00FF,
  parameter logic [31:0] BUILDTIME = 32'd0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                pci_reset,
  hififo_ctrl_regs_if.slave   pio,
  input  logic [32*NCH-1:0]   status,
  input  logic [NCH-1:0]      irq_in,
  output logic                irq_req,
  input  logic                irq_ack,
  output logic [NCH-1:0]      fifo_reset
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLookup = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [5:0]     addr_q, addr_d;
  logic [31:0]    rc_data_q, rc_data_d;
  logic [NCH-1:0] rst_reg_q, rst_reg_d;
  logic [NCH-1:0] irq_status_q, irq_status_d;
  logic           irq_req_q, irq_req_d;
  logic [NCH-1:0] mask;
  logic [31:0]    rd_data;
  logic           rd_clear;

  // Upper write-data bits beyond the channel count carry no meaning here.
  logic unused_wr_data;
  assign unused_wr_data = ^pio.wr_data[63:NCH];

`ifdef HIFIFO_IRQ_MASK_EN
  logic [NCH-1:0] mask_q, mask_d;

  // Mask register load; a link reset blocks a same-cycle write but keeps the value.
  always_comb begin
    mask_d = mask_q;
    if (!pci_reset && pio.wr_valid && pio.wr_addr == 6'd5) begin
      mask_d = pio.wr_data[NCH-1:0];
    end
  end

  // Mask register state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign mask = mask_q;
`else
  assign mask = '0;
`endif

  // Read data mux, evaluated on the captured address during LOOKUP.
  always_comb begin
    rd_data = '0;
    case (addr_q)
      6'd0: rd_data = 32'(irq_status_q);
      6'd1: rd_data = 32'(ENABLE[NCH-1:0]);
      6'd2: rd_data = BUILDTIME;
      6'd3, 6'd4: rd_data = 32'(rst_reg_q);
      6'd5: rd_data = 32'(mask);
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (addr_q == 6'(32 + i)) rd_data = status[32*i +: 32];
        end
      end
    endcase
  end

  // Read FSM next state; rc_data is frozen at the end of LOOKUP.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rc_data_d = rc_data_q;
    case (state_q)
      StIdle: begin
        if (pio.rr_valid) begin
          state_d = StLookup;
          addr_d  = pio.rr_addr;
        end
      end
      StLookup: begin
        state_d   = StResp;
        rc_data_d = rd_data;
      end
      StResp: begin
        if (pio.rc_ready) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    if (pci_reset) state_d = StIdle;
  end

  // FIFO reset register: set/clear writes, forced to all ones by a link reset.
  always_comb begin
    rst_reg_d = rst_reg_q;
    if (pci_reset) begin
      rst_reg_d = '1;
    end else if (pio.wr_valid) begin
      if (pio.wr_addr == 6'd3) begin
        rst_reg_d = rst_reg_q | pio.wr_data[NCH-1:0];
      end else if (pio.wr_addr == 6'd4) begin
        rst_reg_d = rst_reg_q & ~pio.wr_data[NCH-1:0];
      end
    end
  end

  // Interrupt status accumulates every pulse; a word-0 read clears it, but a pulse
  // arriving in the same LOOKUP cycle survives so it is never lost.
  always_comb begin
    rd_clear     = (state_q == StLookup) && (addr_q == 6'd0);
    irq_status_d = (rd_clear ? '0 : irq_status_q) | irq_in;
    irq_req_d    = (irq_req_q & ~irq_ack) | (|(irq_in & ~mask));
    if (pci_reset) begin
      irq_status_d = '0;
      irq_req_d    = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      rc_data_q    <= '0;
      rst_reg_q    <= '1;
      irq_status_q <= '0;
      irq_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rc_data_q    <= rc_data_d;
      rst_reg_q    <= rst_reg_d;
      irq_status_q <= irq_status_d;
      irq_req_q    <= irq_req_d;
    end
  end

  assign pio.rc_valid = (state_q == StResp);
  assign pio.rr_ready = (state_q == StDone);
  assign pio.rc_data  = rc_data_q;
  assign irq_req      = irq_req_q;
  assign fifo_reset   = rst_reg_q;

endmodule

// File: tb/tb_hififo_ctrl_regs.sv
// Self-checking bench for hififo_ctrl_regs with a behavioural register model.
module tb_hififo_ctrl_regs;
  localparam int NCH = 8;
  localparam logic [15:0] EnableTb = 16'h00A5;
  localparam logic [31:0] BuildTb  = 32'h2024_0611;
`ifdef HIFIFO_IRQ_MASK_EN
  localparam bit MaskEn = 1'b1;
`else
  localparam bit MaskEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic pci_reset;
  logic [32*NCH-1:0] status;
  logic [NCH-1:0] irq_in;
  logic irq_req;
  logic irq_ack;
  logic [NCH-1:0] fifo_reset;

  hififo_ctrl_regs_if pio ();

  hififo_ctrl_regs #(
    .NCH(NCH),
    .ENABLE(EnableTb),
    .BUILDTIME(BuildTb)
  ) dut (
    .clock(clk),
    .reset_n(rst_n),
    .pci_reset(pci_reset),
    .pio(pio),
    .status(status),
    .irq_in(irq_in),
    .irq_req(irq_req),
    .irq_ack(irq_ack),
    .fifo_reset(fifo_reset)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // Behavioural model state.
  logic [NCH-1:0] m_rst, m_irq, m_mask;
  bit m_req;
  bit lookup_clr = 1'b0;

  function automatic logic [NCH-1:0] eff_mask();
    return MaskEn ? m_mask : '0;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] r;
    r = '0;
    if (a == 0) r = 32'(m_irq);
    else if (a == 1) r = 32'(EnableTb[NCH-1:0]);
    else if (a == 2) r = BuildTb;
    else if (a == 3 || a == 4) r = 32'(m_rst);
    else if (a == 5) r = 32'(eff_mask());
    else if (a >= 32 && a < 32 + NCH) r = status[32*(a-32) +: 32];
    return r;
  endfunction

  task automatic model_reset();
    m_rst = '1;
    m_irq = '0;
    m_mask = '0;
    m_req = 1'b0;
  endtask

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic tick();
    if (!rst_n) begin
      model_reset();
    end else if (pci_reset) begin
      m_rst = '1;
      m_irq = '0;
      m_req = 1'b0;
    end else begin
      m_req = (m_req && !irq_ack) || ((irq_in & ~eff_mask()) != '0);
      m_irq = (lookup_clr ? '0 : m_irq) | irq_in;
      if (pio.wr_valid) begin
        if (pio.wr_addr == 6'd3) m_rst = m_rst | pio.wr_data[NCH-1:0];
        else if (pio.wr_addr == 6'd4) m_rst = m_rst & ~pio.wr_data[NCH-1:0];
        else if (pio.wr_addr == 6'd5 && MaskEn) m_mask = pio.wr_data[NCH-1:0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [63:0] d);
    pio.wr_valid = 1'b1;
    pio.wr_addr = 6'(a);
    pio.wr_data = d;
    tick();
    pio.wr_valid = 1'b0;
  endtask

  // One read transaction; returns what was observed, comparisons are left to the caller.
  task automatic do_read(input int a, input logic [NCH-1:0] lookup_irq, input int hold,
                         input bit scramble, output logic [31:0] data, output int lat,
                         output bit stable, output bit rr_first, output int rr_pulses,
                         output bit rc_after);
    bit v1;
    data = 'x; lat = -1; stable = 1'b0; rr_first = 1'b0; rr_pulses = 0; rc_after = 1'b1;
    pio.rr_addr = 6'(a);
    pio.rr_valid = 1'b1;
    tick();
    pio.rr_valid = 1'b0;
    v1 = pio.rc_valid;
    irq_in = lookup_irq;
    lookup_clr = (a == 0);
    tick();
    irq_in = '0;
    lookup_clr = 1'b0;
    if (v1) lat = 1;
    else if (pio.rc_valid) lat = 2;
    else begin
      for (int k = 3; k <= 8; k++) begin
        tick();
        if (pio.rc_valid) begin
          lat = k;
          break;
        end
      end
    end
    if (lat < 0) return;
    data = pio.rc_data;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      if (scramble) for (int k = 0; k < NCH; k++) status[32*k +: 32] = $urandom;
      tick();
      if (!pio.rc_valid || pio.rc_data !== data) stable = 1'b0;
    end
    rr_pulses = int'(pio.rr_ready);
    pio.rc_ready = 1'b1;
    tick();
    pio.rc_ready = 1'b0;
    rr_first = pio.rr_ready;
    rc_after = pio.rc_valid;
    rr_pulses += int'(pio.rr_ready);
    for (int k = 0; k < 2; k++) begin
      tick();
      rr_pulses += int'(pio.rr_ready);
    end
  endtask

  logic [31:0] rd;
  int lat, pulses;
  bit stb, rr1, rca;

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (fifo_reset !== 8'hFF) begin n_fail++; $display("FAIL reset_fifo_reset: got %h want ff", fifo_reset); end
    n_tests++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL reset_irq_req: got %b want 0", irq_req); end
    n_tests++; if (pio.rc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rc_valid: got %b want 0", pio.rc_valid); end
    n_tests++; if (pio.rr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rr_ready: got %b want 0", pio.rr_ready); end
    n_tests++; if (pio.rc_data !== 32'h0) begin n_fail++; $display("FAIL reset_rc_data: got %h want 0", pio.rc_data); end
    rst_n = 1'b1;
    // First request straight after release must be taken on the next edge.
    do_read(1, '0, 0, 1'b0, rd, lat, stb, rr1, pulses, rca);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL first_read_latency: got %0d want 2", lat); end
    n_tests++; if (rd !== 32'h0000_00A5) begin n_fail++; $display("FAIL read_enable: got %h want 000000a5", rd); end
    do_read(2, '0, 0, 1'b0, rd, lat, stb, rr1, pulses, rca);
    n_tests++; if (rd !== BuildTb) begin n_fail++; $display("FAIL read_buildtime: got %h want %h", rd, BuildTb); end
  endtask

  task automatic test_reset_reg();
    logic [31:0] exp;
    int a;
    do_write(4, 64'hFF);
    do_write(3, 64'h05);
    n_tests++; if (fifo_reset !== 8'h05) begin n_fail++; $display("FAIL fifo_reset_set_clear: got %h want 05", fifo_reset); end
    do_read(3, '0, 0, 1'b0, rd, lat, stb, rr1, pulses, rca);
    n_tests++; if (rd !== 32'h5) begin n_fail++; $display("FAIL read_reset_reg: got %h want 00000005", rd); end
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: a = 3;
        1: a = 4;
        2: a = 5;
        default: a = $urandom_range(0, 63);
      endcase
      do_write(a, {$urandom, $urandom});
      n_tests++; if (fifo_reset !== m_rst) begin n_fail++; $display("FAIL rand_write_%0d addr %0d: got %h want %h", i, a, fifo_reset, m_rst); end
    end
    for (int a2 = 4; a2 <= 5; a2++) begin
      exp = model_read(a2);
      do_read(a2, '0, 0, 1'b0, rd, lat, stb, rr1, pulses, rca);
      n_tests++; if (rd !== exp) begin n_fail++; $display("FAIL readback_addr_%0d: got %h want %h", a2, rd, exp); end
    end
  endtask

  task automatic test_status_read();
    logic [31:0] exp;
    int a;
    status = '0;
    status[2*32 +: 32] = 32'hCAFE_0002;
    do_read(34, '0, 5, 1'b1, rd, lat, stb, rr1, pulses, rca);
    n_tests++; if (rd !== 32'hCAFE_0002) begin n_fail++; $display("FAIL status2_data: got %h want cafe0002", rd); end
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL status2_latency: got %0d want 2", lat); end
    n_tests++; if (stb !== 1'b1) begin n_fail++; $display("FAIL status2_stable: got %b want 1", stb); end
    n_tests++; if (rr1 !== 1'b1) begin n_fail++; $display("FAIL rr_ready_after_handshake: got %b want 1", rr1); end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL rr_ready_pulse_count: got %0d want 1", pulses); end
    n_tests++; if (rca !== 1'b0) begin n_fail++; $display("FAIL rc_valid_after_handshake: got %b want 0", rca); end
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < NCH; k++) status[32*k +: 32] = $urandom;
      a = ($urandom_range(0, 1) == 0) ? $urandom_range(30, 42) : $urandom_range(0, 63);
      exp = model_read(a);
      do_read(a, '0, $urandom_range(0, 3), 1'b1, rd, lat, stb, rr1, pulses, rca);
      n_tests++; if (rd !== exp || lat !== 2 || stb !== 1'b1) begin
        n_fail++; $display("FAIL rand_read_%0d addr %0d: got %h lat %0d stable %b want %h lat 2 stable 1", i, a, rd, lat, stb, exp);
      end
    end
  endtask

  task automatic test_irq_clear();
    do_read(0, '0, 0, 1'b0, rd, lat, stb, rr1, pulses, rca);
    irq_in = 8'h10;
    tick();
    irq_in = '0;
    tick();
    do_read(0, 8'h01, 0, 1'b0, rd, lat, stb, rr1, pulses, rca);
    n_tests++; if (rd !== 32'h10) begin n_fail++; $display("FAIL irq_status_read: got %h want 00000010", rd); end
    do_read(0, '0, 0, 1'b0, rd, lat, stb, rr1, pulses, rca);
    n_tests++; if (rd !== 32'h01) begin n_fail++; $display("FAIL irq_status_after_clear: got %h want 00000001", rd); end
  endtask

  task automatic test_irq_mask();
    logic [31:0] exp;
    bit held;
    do_read(0, '0, 0, 1'b0, rd, lat, stb, rr1, pulses, rca);
    do_write(5, 64'h02);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_tests++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL irq_req_after_ack: got %b want 0", irq_req); end
    irq_in = 8'h02; tick(); irq_in = '0;
    tick(); tick();
    n_tests++; if (irq_req !== !MaskEn) begin n_fail++; $display("FAIL irq_req_masked_src: got %b want %b", irq_req, !MaskEn); end
    do_read(0, '0, 0, 1'b0, rd, lat, stb, rr1, pulses, rca);
    n_tests++; if (rd !== 32'h02) begin n_fail++; $display("FAIL irq_status_masked_src: got %h want 00000002", rd); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_in = 8'h04; tick(); irq_in = '0;
    held = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (irq_req !== 1'b1) held = 1'b0;
    end
    n_tests++; if (held !== 1'b1) begin n_fail++; $display("FAIL irq_req_held: got %b want 1", held); end
    irq_ack = 1'b1; irq_in = 8'h04; tick(); irq_in = '0;
    n_tests++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL irq_req_ack_with_new_irq: got %b want 1", irq_req); end
    tick(); irq_ack = 1'b0;
    n_tests++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL irq_req_acked: got %b want 0", irq_req); end
    do_write(5, 64'($urandom_range(0, 255)));
    for (int i = 0; i < 40; i++) begin
      irq_in = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
      irq_ack = ($urandom_range(0, 3) == 0);
      tick();
      n_tests++; if (irq_req !== m_req) begin n_fail++; $display("FAIL rand_irq_req_%0d: got %b want %b", i, irq_req, m_req); end
    end
    irq_in = '0;
    irq_ack = 1'b0;
    exp = model_read(0);
    do_read(0, '0, 0, 1'b0, rd, lat, stb, rr1, pulses, rca);
    n_tests++; if (rd !== exp) begin n_fail++; $display("FAIL rand_irq_status: got %h want %h", rd, exp); end
  endtask

  task automatic test_pci_reset();
    logic [31:0] exp;
    int cnt;
    do_write(5, 64'h3C);
    do_write(4, 64'hFF);
    pio.rr_addr = 6'd1; pio.rr_valid = 1'b1; tick(); pio.rr_valid = 1'b0;
    tick();
    n_tests++; if (pio.rc_valid !== 1'b1) begin n_fail++; $display("FAIL pci_pre_resp: got %b want 1", pio.rc_valid); end
    pci_reset = 1'b1; irq_in = 8'h80;
    pio.wr_valid = 1'b1; pio.wr_addr = 6'd4; pio.wr_data = 64'hFF;
    tick();
    pci_reset = 1'b0; irq_in = '0; pio.wr_valid = 1'b0;
    n_tests++; if (pio.rc_valid !== 1'b0) begin n_fail++; $display("FAIL pci_rc_valid: got %b want 0", pio.rc_valid); end
    n_tests++; if (fifo_reset !== 8'hFF) begin n_fail++; $display("FAIL pci_fifo_reset: got %h want ff", fifo_reset); end
    n_tests++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL pci_irq_req: got %b want 0", irq_req); end
    cnt = int'(pio.rr_ready);
    for (int k = 0; k < 3; k++) begin
      tick();
      cnt += int'(pio.rr_ready);
    end
    n_tests++; if (cnt !== 0) begin n_fail++; $display("FAIL pci_no_rr_ready: got %0d pulses want 0", cnt); end
    exp = MaskEn ? 32'h3C : 32'h0;
    do_read(5, '0, 0, 1'b0, rd, lat, stb, rr1, pulses, rca);
    n_tests++; if (rd !== exp) begin n_fail++; $display("FAIL pci_mask_kept: got %h want %h", rd, exp); end
    do_read(0, '0, 0, 1'b0, rd, lat, stb, rr1, pulses, rca);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL pci_irq_status: got %h want 0", rd); end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_write(5, 64'h0);
    do_write(4, 64'hFF);
    irq_in = 8'h01; tick(); irq_in = '0;
    status[32 +: 32] = 32'h1234_5678;
    pio.rr_addr = 6'd33; pio.rr_valid = 1'b1; tick(); pio.rr_valid = 1'b0;
    tick();
    ok = (pio.rc_valid === 1'b1) && (irq_req === 1'b1);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL async_pre_state: got rc_valid %b irq_req %b want 1 1", pio.rc_valid, irq_req); end
    #2 rst_n = 1'b0;
    #1;
    ok = (fifo_reset === 8'hFF) && (irq_req === 1'b0) && (pio.rc_valid === 1'b0)
         && (pio.rr_ready === 1'b0) && (pio.rc_data === 32'h0);
    n_tests++; if (!ok) begin
      n_fail++; $display("FAIL async_reset_outputs: got fifo %h irq %b rcv %b rrr %b rcd %h want ff 0 0 0 0",
                         fifo_reset, irq_req, pio.rc_valid, pio.rr_ready, pio.rc_data);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_read(33, '0, 0, 1'b0, rd, lat, stb, rr1, pulses, rca);
    n_tests++; if (rd !== 32'h1234_5678 || lat !== 2) begin n_fail++; $display("FAIL read_after_async_reset: got %h lat %0d want 12345678 lat 2", rd, lat); end
    do_read(5, '0, 0, 1'b0, rd, lat, stb, rr1, pulses, rca);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mask_after_async_reset: got %h want 0", rd); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pci_reset = 1'b0;
    status = '0;
    irq_in = '0;
    irq_ack = 1'b0;
    pio.wr_valid = 1'b0;
    pio.wr_addr = '0;
    pio.wr_data = '0;
    pio.rr_valid = 1'b0;
    pio.rr_addr = '0;
    pio.rc_ready = 1'b0;
    test_reset();
    test_reset_reg();
    test_status_read();
    test_irq_clear();
    test_irq_mask();
    test_pci_reset();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hififo_ctrl_regs.md
HIFIFO_CTRL_REGS -- requirements
Module: hififo_ctrl_regs

Interface
REQ-001 SHALL have parameter NCH, default 8, meaning FIFO channel count (legal 1..16).
REQ-002 SHALL have parameter ENABLE, default 8'hFF (NCH bits used), meaning channel-present mask returned at word 1.
REQ-003 SHALL have parameter BUILDTIME, default 32'd0, meaning build stamp returned at word 2.
REQ-004 SHALL have port clock  in  1  single clock for all logic.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port pci_reset  in  1  synchronous link reset, active high.
REQ-007 SHALL have ports wr_valid in 1, wr_addr in 6, wr_data in 64  PIO write strobe, word index, data.
REQ-008 SHALL have ports rr_valid in 1, rr_addr in 6, rr_ready out 1  PIO read request and its one-cycle release pulse.
REQ-009 SHALL have ports rc_valid out 1, rc_ready in 1, rc_data out 32  read-completion data to TX.
REQ-010 SHALL have port status  in  32*NCH  per-channel status words, channel i at bits [32i+31:32i].
REQ-011 SHALL have port irq_in  in  NCH  per-channel interrupt pulses.
REQ-012 SHALL have ports irq_req out 1, irq_ack in 1  interrupt request to core, held until ack.
REQ-013 SHALL have port fifo_reset  out  NCH  per-channel FIFO reset, registered.

Function
REQ-014 SHALL decode reads: 0 irq_status; 1 ENABLE; 2 BUILDTIME; 3 and 4 reset register; 5 mask register; 32+i status[i] for i<NCH; all other addresses 0; unused upper bits 0.
REQ-015 SHALL decode writes when wr_valid: 3 sets reset bits (reg |= wr_data[NCH-1:0]); 4 clears (reg &= ~wr_data); 5 loads mask; others ignored.
REQ-016 SHALL run read FSM IDLE -> LOOKUP (rr_valid seen, address captured) -> RESP (rc_valid=1, rc_data stable) -> DONE on rc_valid&rc_ready (rr_ready=1 one cycle) -> IDLE.
REQ-017 SHALL assert rc_valid exactly 2 cycles after rr_valid is sampled in IDLE; rr_valid is ignored outside IDLE.
REQ-018 SHALL capture rc_data in LOOKUP; later changes to sources SHALL NOT alter rc_data while rc_valid.
REQ-019 SHALL latch irq_status |= irq_in every cycle, regardless of mask.
REQ-020 SHALL clear irq_status in the LOOKUP cycle of a word-0 read, except bits whose irq_in is high that same cycle, which SHALL remain set.
REQ-021 SHALL set irq_req when (irq_in & ~mask) != 0 and hold it until irq_ack; an unmasked irq_in in the ack cycle SHALL keep irq_req high.
REQ-022 SHALL drive fifo_reset directly from the reset register.
REQ-023 SHALL give pci_reset priority over a same-cycle write: reset register all ones, irq_status 0, irq_req 0, FSM to IDLE with rc_valid 0 and no rr_ready pulse; mask unchanged.

Reset
REQ-024 SHALL on reset_n low asynchronously force: fifo_reset all ones, irq_status 0, mask 0, irq_req 0, rc_valid 0, rr_ready 0, rc_data 0, FSM IDLE.
REQ-025 SHALL release reset synchronously to clock; first rr_valid accepted on the first edge after release.

Configuration
REQ-026 SHALL, with HIFIFO_IRQ_MASK_EN defined, implement the mask register (write 5, read 5) gating irq_req per REQ-021.
REQ-027 SHALL, without HIFIFO_IRQ_MASK_EN, omit the mask register: mask treated as 0, write 5 ignored, read 5 returns 0.

Verification
REQ-028 SHALL cover: NCH=8, write addr 4 data 0xFF, then addr 3 data 0x05 -> fifo_reset 0x05; read addr 3 -> rc_data 0x00000005.
REQ-029 SHALL cover: rr_valid addr 34 with status[2]=0xCAFE0002 -> rc_valid 2 cycles later, data 0xCAFE0002; rc_ready held 0 for 5 cycles -> data stable; rr_ready pulses once, cycle after handshake.
REQ-030 SHALL cover: irq_in=0x10, read addr 0 with irq_in=0x01 in LOOKUP cycle -> rc_data 0x10, irq_status afterwards 0x01.
REQ-031 SHALL cover (mask enabled): write addr 5 data 0x02, irq_in=0x02 -> irq_req stays 0, irq_status 0x02; irq_in=0x04 -> irq_req 1 until irq_ack.
REQ-032 SHALL cover: pci_reset asserted in RESP with write addr 4 same cycle -> rc_valid 0 next cycle, no rr_ready, fifo_reset 0xFF; reset_n low mid-read -> all outputs per REQ-024 immediately.
